logic_op_scheduler: RTL and testbench



---
 rtl/logic_op_scheduler.sv | 130 +++++++++++++
 tb/tb_logic_op_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/logic_op_scheduler.sv
// logic_op_scheduler: two requesters share one bitwise logic unit.
// Round-robin arbitration in IDLE, one EXEC cycle, then a held RESP
// until the consumer takes the result.
module logic_op_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [1:0]     req0_op,
  input  logic [WIDTH:1] req0_a,
  input  logic [WIDTH:1] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [1:0]     req1_op,
  input  logic [WIDTH:1] req1_a,
  input  logic [WIDTH:1] req1_b,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [WIDTH:1] rsp_data,
  input  logic           rsp_ready,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic           last_grant;
  logic [1:0]     op_q;
  logic [WIDTH:1] a_q;
  logic [WIDTH:1] b_q;
  logic           id_q;

  logic           grant0;
  logic           grant1;
  logic [WIDTH:1] unit_y;

  // Round-robin grant: a lone requester always wins; on contention the
  // requester that did not win last time gets the slot.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Shared logic unit, fed only from latched operands so no request input
  // reaches the response path combinationally.
  always_comb begin
    unit_y = '0;
    unique case (op_q)
      2'b00:   unit_y = a_q & b_q;
      2'b01:   unit_y = a_q | b_q;
      2'b10:   unit_y = a_q ^ b_q;
      default: unit_y = ~a_q;
    endcase
  end

  // Scheduler FSM with registered response and busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant0) begin
            op_q       <= req0_op;
            a_q        <= req0_a;
            b_q        <= req0_b;
            id_q       <= 1'b0;
            last_grant <= 1'b0;
            busy       <= 1'b1;
            state      <= EXEC;
          end else if (grant1) begin
            op_q       <= req1_op;
            a_q        <= req1_a;
            b_q        <= req1_b;
            id_q       <= 1'b1;
            last_grant <= 1'b1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= unit_y;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed, table-driven bench for logic_op_scheduler.
module tb_logic_op_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [16:1] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_id, rsp_ready = 1'b1, busy;
  logic [16:1] rsp_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic_op_scheduler #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [16:1] a;
    logic [16:1] b;
    logic [16:1] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready high; optional operand change after accept.
  task automatic do_op(input logic id, input logic [1:0] op, input logic [16:1] a,
                       input logic [16:1] b, input logic [16:1] exp, input bit scramble);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("accept_ready", {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (scramble) begin
      req0_a = 16'hFFFF; req0_b = 16'hFFFF; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
    end
    #1;
    chk("exec_busy_valid", {30'd0, busy, rsp_valid}, 32'd2);
    tick();
    chk("resp_busy_valid", {30'd0, busy, rsp_valid}, 32'd3);
    chk("resp_data", {16'd0, rsp_data}, {16'd0, exp});
    chk("resp_id", {31'd0, rsp_id}, {31'd0, id});
    chk("resp_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    chk("back_idle", {30'd0, busy, rsp_valid}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 2'b01, 16'hF0F0, 16'h0FF0, 16'hFFF0};
    tbl[1] = '{1'b1, 2'b00, 16'hAAAA, 16'h6666, 16'h2222};
    tbl[2] = '{1'b1, 2'b01, 16'hAAAA, 16'h6666, 16'hEEEE};
    tbl[3] = '{1'b1, 2'b10, 16'hAAAA, 16'h6666, 16'hCCCC};
    tbl[4] = '{1'b1, 2'b11, 16'hAAAA, 16'h6666, 16'h5555};
    tbl[5] = '{1'b0, 2'b00, 16'hFFFF, 16'h1234, 16'h1234};
    tbl[6] = '{1'b0, 2'b10, 16'h1234, 16'h1234, 16'h0000};
    tbl[7] = '{1'b0, 2'b11, 16'h0000, 16'hFFFF, 16'hFFFF};

    // Reset values
    #12;
    chk("rst_outputs", {27'd0, rsp_valid, rsp_id, busy, req1_ready, req0_ready}, 32'd0);
    chk("rst_data", {16'd0, rsp_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Table sweep
    for (int i = 0; i < 8; i++)
      do_op(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);

    // Idle with no requests: nothing granted, stays idle
    tick();
    chk("idle_quiet", {29'd0, busy, req1_ready, req0_ready}, 32'd0);

    // Contention fairness after a fresh reset
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    req0_op = 2'b10; req0_a = 16'h0F0F; req0_b = 16'h00FF;
    req1_op = 2'b11; req1_a = 16'h00F0; req1_b = 16'h0000;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 3 == 0)
        chk("rr_grant", {30'd0, req1_ready, req0_ready}, ((c / 3) % 2 == 0) ? 32'd1 : 32'd2);
      else
        chk("rr_no_grant_busy", {29'd0, busy, req1_ready, req0_ready}, 32'd4);
      if (c % 3 == 2) begin
        chk("rr_rsp_id", {31'd0, rsp_id}, ((c / 3) % 2 == 0) ? 32'd0 : 32'd1);
        chk("rr_rsp_data", {16'd0, rsp_data}, ((c / 3) % 2 == 0) ? 32'h0FF0 : 32'hFF0F);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // Backpressure with req1 waiting
    req0_op = 2'b00; req0_a = 16'h0F0F; req0_b = 16'h00FF; req0_valid = 1'b1;
    #1;
    chk("bp_accept", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_op = 2'b01; req1_a = 16'h1200; req1_b = 16'h0034; req1_valid = 1'b1;
    rsp_ready = 1'b0;
    #1;
    chk("bp_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", {13'd0, rsp_valid, rsp_id, req1_ready, rsp_data}, {13'd0, 3'b100, 16'h000F});
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
    tick();
    chk("bp_req1_granted", {30'd0, req1_ready, req0_ready}, 32'd2);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("bp_req1_result", {15'd0, rsp_id, rsp_data}, {15'd0, 1'b1, 16'h1234});
    tick();

    // Reset mid-operation: accepted by req0, reset during EXEC
    req0_op = 2'b01; req0_a = 16'h8000; req0_b = 16'h0001; req0_valid = 1'b1;
    #1;
    chk("rm_accept", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rm_async_drop", {30'd0, busy, rsp_valid}, 32'd0);
    tick();
    chk("rm_no_rsp", {30'd0, busy, rsp_valid}, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    chk("rm_still_idle", {30'd0, busy, rsp_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rm_req0_first", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rm_result", {15'd0, rsp_id, rsp_data}, {15'd0, 1'b0, 16'h8001});
    tick();

    // Operand capture: inputs change the cycle after accept
    do_op(1'b0, 2'b10, 16'h1234, 16'h00FF, 16'h12CB, 1'b1);
    do_op(1'b1, 2'b00, 16'h5A5A, 16'h0FF0, 16'h0A50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
